spi_target_rx: RTL



---
 rtl/spi_target_rx_if.sv | 36 +++
 rtl/spi_target_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_target_rx_if.sv
// Pin-side and stream-side signals of spi_target_rx; slave is the target's view,
// master is the view of whatever drives the pins and consumes the streams.
interface spi_target_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                  spi_sck_i;
  logic                  spi_nss_i;
  logic                  spi_mosi_i;
  logic                  spi_miso_o;
  logic                  spi_miso_en_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic                  rx_ready_i;
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic                  rx_overflow_o;
  logic                  tx_underrun_o;
  logic                  frame_abort_o;
  logic [LW-1:0]         rx_level_o;

  modport slave (
    input  spi_sck_i, spi_nss_i, spi_mosi_i, rx_ready_i, tx_data_i, tx_valid_i,
    output spi_miso_o, spi_miso_en_o, rx_data_o, rx_valid_o, tx_ready_o,
           rx_overflow_o, tx_underrun_o, frame_abort_o, rx_level_o
  );

  modport master (
    output spi_sck_i, spi_nss_i, spi_mosi_i, rx_ready_i, tx_data_i, tx_valid_i,
    input  spi_miso_o, spi_miso_en_o, rx_data_o, rx_valid_o, tx_ready_o,
           rx_overflow_o, tx_underrun_o, frame_abort_o, rx_level_o
  );
endinterface

// File: rtl/spi_target_rx.sv
// SPI target receiver: SCK/NSS/MOSI oversampled in clk_i, MISO reply from a one-word
// holding register, received words queued in a first-word fall-through FIFO.
module spi_target_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input logic            clk_i,
  input logic            rst_n_i,
  spi_target_rx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_next;

  logic [2:0]            sck_sync, nss_sync;
  logic [1:0]            mosi_sync;
  logic                  sck_rise, sck_fall, nss_rise, nss_fall;
  logic                  lead_edge, trail_edge, sample_edge, shift_edge;
  logic                  start, stop, sample, shift, word_done, load;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift, tx_hold, push_data;
  logic                  tx_full, skip, push, underrun_pend, underrun, abort, overflow;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, level;
  logic                  full, pop, accept;

  // NSS resets to "asserted" so a select held low through reset produces no falling edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync  <= {3{CPOL}};
      nss_sync  <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[1:0], bus.spi_sck_i};
      nss_sync  <= {nss_sync[1:0], bus.spi_nss_i};
      mosi_sync <= {mosi_sync[0], bus.spi_mosi_i};
    end
  end

  assign sck_rise    = sck_sync[1] & ~sck_sync[2];
  assign sck_fall    = ~sck_sync[1] & sck_sync[2];
  assign nss_rise    = nss_sync[1] & ~nss_sync[2];
  assign nss_fall    = ~nss_sync[1] & nss_sync[2];
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    stop       = 1'b0;
    sample     = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (nss_fall) begin
          state_next = ACTIVE;
          start      = 1'b1;
        end
      end
      ACTIVE: begin
        if (nss_rise) begin
          state_next = IDLE;
          stop       = 1'b1;
        end else begin
          sample = sample_edge;
          shift  = shift_edge;
        end
      end
    endcase
  end

  assign word_done = sample && (bit_cnt == CW'(DATA_WIDTH - 1));
  assign load      = start || word_done;

  // An empty reload at a word boundary only counts as underrun once the next word
  // actually begins; a frame that ends on the boundary reports nothing.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      tx_hold       <= '0;
      tx_full       <= 1'b0;
      skip          <= 1'b0;
      push          <= 1'b0;
      push_data     <= '0;
      underrun_pend <= 1'b0;
      underrun      <= 1'b0;
      abort         <= 1'b0;
    end else begin
      push     <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;
      if (bus.tx_valid_i && !tx_full) begin
        tx_hold <= bus.tx_data_i;
        tx_full <= 1'b1;
      end
      if (start) bit_cnt <= '0;
      if (sample) begin
        rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_sync[1]};
        skip     <= 1'b0;
        if (bit_cnt == '0 && underrun_pend) begin
          underrun      <= 1'b1;
          underrun_pend <= 1'b0;
        end
        if (word_done) begin
          bit_cnt   <= '0;
          push      <= 1'b1;
          push_data <= {rx_shift, mosi_sync[1]};
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (shift) begin
        if (!skip) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        skip <= 1'b0;
      end
      // The reload presents the MSB itself, so the next shift edge must leave it in place.
      if (load) begin
        tx_shift <= tx_full ? tx_hold : '1;
        skip     <= 1'b1;
        if (tx_full) tx_full <= 1'b0;
        if (start) underrun      <= !tx_full;
        else       underrun_pend <= !tx_full;
      end
      if (stop) begin
        abort         <= (bit_cnt != '0);
        bit_cnt       <= '0;
        underrun_pend <= 1'b0;
      end
    end
  end

  assign level  = wr_ptr - rd_ptr;
  assign full   = (level == (AW + 1)'(FIFO_DEPTH));
  assign pop    = (level != '0) && bus.rx_ready_i;
  assign accept = push && (!full || pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      overflow <= push && !accept;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign bus.rx_data_o     = (level != '0) ? mem[rd_ptr[AW-1:0]] : '0;
  assign bus.rx_valid_o    = (level != '0);
  assign bus.rx_level_o    = level;
  assign bus.tx_ready_o    = !tx_full;
  assign bus.spi_miso_en_o = (state == ACTIVE);
  assign bus.spi_miso_o    = (state == ACTIVE) && tx_shift[DATA_WIDTH-1];
  assign bus.rx_overflow_o = overflow;
  assign bus.tx_underrun_o = underrun;
  assign bus.frame_abort_o = abort;

endmodule
